// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-entry holding register and per-frame parity/stop config.
// Latency: frame accepted at edge T drives the start bit from edge T+1 when idle; back-to-back frames have no idle gap.
// Backpressure: o_ready reflects the holding register only; a new frame is accepted whenever it is empty.
module uart_tx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_CNT     = $clog2(2*OVERSAMPLE)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_parity_en,
  input  logic               i_parity_odd,
  input  logic [1:0]         i_stop_sel,
  output logic               o_ready,
  output logic               o_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_IDX = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, state_nxt;

  // Holding register; o_ready doubles as its "empty" flag.
  logic [NB_DATA-1:0] hold_data;
  logic               hold_par_en;
  logic               hold_par_odd;
  logic [1:0]         hold_stop;

  // Frame in flight, captured from the holding register at load time.
  logic [NB_DATA-1:0] shift;
  logic               par_en;
  logic               par_bit;
  logic [1:0]         stop_sel;
  logic [NB_CNT-1:0]  cnt;
  logic [NB_IDX-1:0]  idx;

  logic [NB_CNT-1:0]  stop_last;
  logic               bit_end, stop_end, seg_end, last_bit, load, accept;
  logic [NB_IDX-1:0]  idx_nxt;
  logic               data_nxt, busy_nxt, done_nxt;

  // Decode the last tick of the stop period from the latched stop selection.
  always_comb begin
    case (stop_sel)
      2'b00:   stop_last = NB_CNT'(OVERSAMPLE - 1);
      2'b01:   stop_last = NB_CNT'(3 * OVERSAMPLE / 2 - 1);
      default: stop_last = NB_CNT'(2 * OVERSAMPLE - 1);
    endcase
  end

  assign bit_end  = i_tick && (cnt == NB_CNT'(OVERSAMPLE - 1));
  assign stop_end = i_tick && (cnt == stop_last);
  assign seg_end  = (state == STOP) ? stop_end : bit_end;
  assign last_bit = (idx == NB_IDX'(NB_DATA - 1));
  // Shifter is refilled either from idle or straight out of the last stop tick.
  assign load     = !o_ready && ((state == IDLE) || ((state == STOP) && stop_end));
  assign accept   = i_valid && o_ready;
  assign idx_nxt  = ((state == DATA) && bit_end) ? idx + NB_IDX'(1) : idx;

  // State register and registered line outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      o_data <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_data <= data_nxt;
      o_busy <= busy_nxt;
      o_done <= done_nxt;
    end
  end

  // Next-state logic; without a tick only the idle load can move the FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!o_ready) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_bit) state_nxt = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (stop_end) state_nxt = o_ready ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    data_nxt = 1'b1;
    case (state_nxt)
      START:   data_nxt = 1'b0;
      DATA:    data_nxt = shift[idx_nxt];
      PARITY:  data_nxt = par_bit;
      default: data_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && stop_end;
  end

  // Holding register: filled on handshake, emptied when moved into the shifter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ready      <= 1'b1;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_odd <= 1'b0;
      hold_stop    <= 2'b00;
    end else if (accept) begin
      o_ready      <= 1'b0;
      hold_data    <= i_data;
      hold_par_en  <= i_parity_en;
      hold_par_odd <= i_parity_odd;
      hold_stop    <= i_stop_sel;
    end else if (load) begin
      o_ready <= 1'b1;
    end
  end

  // Shifter, frame config, tick counter and bit index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop_sel <= 2'b00;
      cnt      <= '0;
      idx      <= '0;
    end else if (load) begin
      shift    <= hold_data;
      par_en   <= hold_par_en;
      par_bit  <= (^hold_data) ^ hold_par_odd;
      stop_sel <= hold_stop;
      cnt      <= '0;
      idx      <= '0;
    end else begin
      if (i_tick && (state != IDLE))
        cnt <= seg_end ? '0 : cnt + NB_CNT'(1);
      idx <= idx_nxt;
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit/2-stop transmitter. Data width and oversampling are compile-time parameters; parity (none/even/odd) and stop length (1, 1.5, 2) are selectable per frame. A one-entry holding register allows back-to-back frames with no idle gap. Sits between the baud-rate tick generator and the UART TX pin, fed by the host-side valid/ready stream.

Parameters:
NB_DATA, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, i_tick pulses per bit period; must be even and >= 4.
NB_CNT, $clog2(2*OVERSAMPLE), width of the tick counter (derived; do not override).

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous reset, active-high.
i_tick  in  1  baud oversample strobe, one i_clk cycle wide.
i_valid  in  1  frame offered on i_data/config.
i_data  in  NB_DATA  frame payload, LSB transmitted first.
i_parity_en  in  1  1 = append parity bit.
i_parity_odd  in  1  0 = even parity, 1 = odd parity; ignored when i_parity_en=0.
i_stop_sel  in  2  00 = 1 stop bit, 01 = 1.5, 10 = 2, 11 = treated as 2.
o_ready  out  1  holding register empty; registered.
o_data  out  1  serial line, idle high; registered.
o_busy  out  1  high while state != IDLE; registered.
o_done  out  1  one-cycle pulse when the last stop tick completes.

Behaviour:
- Reset (i_clk edge with i_reset=1): o_data=1, o_ready=1, o_busy=0, o_done=0, state=IDLE, hold register empty, counters 0. Reset mid-frame aborts immediately; the line returns high the next cycle and the queued frame is discarded.
- Handshake: transfer at the edge where i_valid && o_ready. i_data, i_parity_en, i_parity_odd, i_stop_sel are latched together into the hold register. o_ready drops at that same edge and rises at the edge where the hold register is moved into the shifter. i_valid while o_ready=0 is ignored; no data change is required of the source until ready.
- States: IDLE, START, DATA, PARITY, STOP (one-hot or encoded; implementer's choice).
- IDLE: o_data=1. If hold is full, load shifter+config from hold, clear hold, go START, tick counter=0.
- Latency: accept at edge T, then o_data=0 from edge T+1 (state START) when the transmitter was IDLE.
- Bit timing: every bit lasts exactly OVERSAMPLE i_tick pulses. The counter increments only on i_tick. The tick with counter==OVERSAMPLE-1 ends the bit (counter to 0). Cycles without i_tick never change state.
- START: o_data=0; at end, go DATA with bit index 0.
- DATA: o_data=shift[idx]; at end of bit, if idx==NB_DATA-1 go PARITY when parity is enabled, else STOP; otherwise idx+1.
- PARITY: o_data = XOR of all data bits, inverted when odd is selected; lasts one bit period, then STOP.
- STOP: o_data=1; length is OVERSAMPLE, 3*OVERSAMPLE/2, or 2*OVERSAMPLE ticks per latched stop select. At the last stop tick o_done pulses for one cycle. Next state is START with the hold loaded (no idle cycle, back-to-back) if hold is full, else IDLE.
- o_busy=0 only in IDLE. o_ready is independent of the state (hold register only), so a second frame may be accepted during START/DATA/PARITY/STOP.
- Config changes on the inputs mid-frame have no effect on the frame in flight.

Test Plan:
1. OVERSAMPLE=16, i_tick every cycle, 8N1, i_data=0x55 -> o_data: 16 cycles 0, bits 1,0,1,0,1,0,1,0 (16 cycles each), 16 cycles 1; o_done pulses once at cycle 160 after start; o_busy high 160 cycles.
2. 8E2, i_data=0xA7 (five ones) -> parity bit=1; stop high 32 cycles. Repeat odd, i_data=0x00 -> parity bit=1; even, 0x00 -> parity bit=0.
3. 1.5 stop, 8N1.5 -> stop period exactly 24 ticks, then IDLE; o_done on the 24th stop tick.
4. Back-to-back: i_valid held high with 0x12 then 0x34 -> second accepted during the first frame's START (o_ready low 1 cycle, then high). Second start bit begins the cycle after the first frame's last stop tick; o_data shows no high gap beyond the stop length. Third offer waits with o_ready=0 until the second leaves hold.
5. Sparse ticks: i_tick every 4th cycle, 0xFF, 8N1 -> each bit spans 64 clocks; state frozen between ticks.
6. Reset asserted mid-DATA with a frame queued -> next cycle o_data=1, o_ready=1, o_busy=0. The queued frame is never transmitted; a new frame after reset transmits normally.
